// File: rtl/csr_ctrl.sv
// csr_ctrl: machine-mode CSR file with interrupt entry, MRET and WFI handling.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   csr_op_i/addr_i/wdata_i     CSR instruction in EXE (funct3, address, operand)
//   csr_src_zero_i              rs1 index / zimm is zero (suppresses set/clear writes)
//   exe_valid_i, exe_pc_i       EXE holds a real instruction, and its PC
//   mret_i, wfi_i               EXE instruction is MRET / WFI
//   ext_irq_i, timer_irq_i      level-sensitive interrupt lines
//   retire_i                    one instruction retires this cycle
//   csr_rdata_o                 pre-write CSR value (combinational)
//   csr_int_o, csr_mret_o       interrupt / MRET taken this cycle (redirect + flush)
//   csr_pc_o                    redirect target while csr_int_o or csr_mret_o
//   csr_stall_o                 hold the pipeline while waiting in WFI
module csr_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        csr_src_zero_i,
  input  logic        exe_valid_i,
  input  logic [31:0] exe_pc_i,
  input  logic        mret_i,
  input  logic        wfi_i,
  input  logic        ext_irq_i,
  input  logic        timer_irq_i,
  input  logic        retire_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_int_o,
  output logic        csr_mret_o,
  output logic [31:0] csr_pc_o,
  output logic        csr_stall_o
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_W  = 64;
  localparam int unsigned ADDR_W = 12;

  localparam int unsigned MIE_BIT  = 3;
  localparam int unsigned MPIE_BIT = 7;
  localparam int unsigned MTIE_BIT = 7;
  localparam int unsigned MEIE_BIT = 11;

  localparam logic [ADDR_W-1:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [ADDR_W-1:0] ADDR_MIE      = 12'h304;
  localparam logic [ADDR_W-1:0] ADDR_MTVEC    = 12'h305;
  localparam logic [ADDR_W-1:0] ADDR_MEPC     = 12'h341;
  localparam logic [ADDR_W-1:0] ADDR_MIP      = 12'h344;
  localparam logic [ADDR_W-1:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [ADDR_W-1:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [ADDR_W-1:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [ADDR_W-1:0] ADDR_MINSTRETH= 12'hB82;

  localparam logic [XLEN-1:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [XLEN-1:0] MSTATUS_MPP   = 32'h0000_1800;
  localparam logic [XLEN-1:0] MIE_WMASK     = 32'h0000_0880;
  localparam logic [XLEN-1:0] ALIGN_MASK    = 32'hFFFF_FFFC;

  typedef enum logic {ST_RUN = 1'b0, ST_WFI = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_mstatus;
  logic [XLEN-1:0]   r_mie;
  logic [XLEN-1:0]   r_mtvec;
  logic [XLEN-1:0]   r_mepc;
  logic [CNT_W-1:0]  r_mcycle;
  logic [CNT_W-1:0]  r_minstret;

  logic [XLEN-1:0]   w_old;
  logic [XLEN-1:0]   w_new;
  logic              w_wr_en;
  logic              w_do_write;
  logic              w_wake;
  logic              w_pending;
  logic              w_int_run;
  logic              w_int_wfi;
  logic              w_mret;
  logic [XLEN-1:0]   w_pc_plus4;

  assign w_wake = (r_mie[MEIE_BIT] & ext_irq_i) | (r_mie[MTIE_BIT] & timer_irq_i);
  assign w_pending  = r_mstatus[MIE_BIT] & w_wake;
  assign w_pc_plus4 = exe_pc_i + 32'd4;

  // CSR read mux (pre-write value)
  always_comb begin
    w_old = '0;
    case (csr_addr_i)
      ADDR_MSTATUS:   w_old = r_mstatus | MSTATUS_MPP;
      ADDR_MIE:       w_old = r_mie;
      ADDR_MTVEC:     w_old = r_mtvec;
      ADDR_MEPC:      w_old = r_mepc;
      ADDR_MIP:       w_old = {20'd0, ext_irq_i, 3'd0, timer_irq_i, 7'd0};
      ADDR_MCYCLE:    w_old = r_mcycle[31:0];
      ADDR_MCYCLEH:   w_old = r_mcycle[63:32];
      ADDR_MINSTRET:  w_old = r_minstret[31:0];
      ADDR_MINSTRETH: w_old = r_minstret[63:32];
      default:        w_old = '0;
    endcase
  end

  // Write value per operation; set/clear with a zero source never writes
  always_comb begin
    w_new   = '0;
    w_wr_en = 1'b0;
    case (csr_op_i)
      3'b001, 3'b101: begin w_new = csr_wdata_i;          w_wr_en = 1'b1;            end
      3'b010, 3'b110: begin w_new = w_old | csr_wdata_i;  w_wr_en = ~csr_src_zero_i; end
      3'b011, 3'b111: begin w_new = w_old & ~csr_wdata_i; w_wr_en = ~csr_src_zero_i; end
      default: ;
    endcase
  end

  assign csr_rdata_o = (csr_op_i[1:0] == 2'b00) ? '0 : w_old;
  assign w_do_write  = w_wr_en & exe_valid_i & (r_state == ST_RUN) & ~w_int_run;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and event outputs; all quiet while in reset
  always_comb begin
    w_state_nxt = r_state;
    csr_int_o   = 1'b0;
    csr_mret_o  = 1'b0;
    csr_stall_o = 1'b0;
    csr_pc_o    = '0;
    w_int_run   = 1'b0;
    w_int_wfi   = 1'b0;
    w_mret      = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_RUN: begin
          if (exe_valid_i) begin
            if (w_pending) begin
              w_int_run = 1'b1;
              csr_int_o = 1'b1;
              csr_pc_o  = r_mtvec;
            end else if (mret_i) begin
              w_mret     = 1'b1;
              csr_mret_o = 1'b1;
              csr_pc_o   = r_mepc;
            end else if (wfi_i && !w_wake) begin
              w_state_nxt = ST_WFI;
            end
          end
        end
        ST_WFI: begin
          if (!w_wake) begin
            csr_stall_o = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
            if (r_mstatus[MIE_BIT]) begin
              w_int_wfi = 1'b1;
              csr_int_o = 1'b1;
              csr_pc_o  = r_mtvec;
            end
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // CSR storage and counters; trap/return updates override a same-cycle write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mstatus  <= '0;
      r_mie      <= '0;
      r_mtvec    <= '0;
      r_mepc     <= '0;
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
      if (retire_i) r_minstret <= r_minstret + 64'd1;
      if (w_do_write) begin
        case (csr_addr_i)
          ADDR_MSTATUS: r_mstatus <= w_new & MSTATUS_WMASK;
          ADDR_MIE:     r_mie     <= w_new & MIE_WMASK;
          ADDR_MTVEC:   r_mtvec   <= w_new & ALIGN_MASK;
          ADDR_MEPC:    r_mepc    <= w_new & ALIGN_MASK;
          default: ;
        endcase
      end
      if (w_int_run || w_int_wfi) begin
        // interrupt in RUN re-executes the EXE instruction; after WFI resume past it
        r_mepc              <= (w_int_run ? exe_pc_i : w_pc_plus4) & ALIGN_MASK;
        r_mstatus[MPIE_BIT] <= r_mstatus[MIE_BIT];
        r_mstatus[MIE_BIT]  <= 1'b0;
      end else if (w_mret) begin
        r_mstatus[MIE_BIT]  <= r_mstatus[MPIE_BIT];
        r_mstatus[MPIE_BIT] <= 1'b1;
      end
    end
  end

endmodule

// File: doc/csr_ctrl.md
CSR_CTRL -- requirements
Module: csr_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 csr_op_i  input  3  funct3 of CSR instruction in EXE: 000 none, 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 100 treated as none.
REQ-004 csr_addr_i  input  12  CSR address.
REQ-005 csr_wdata_i  input  32  rs1 value, or zero-extended zimm for I-variants.
REQ-006 csr_src_zero_i  input  1  rs1 index / zimm equals 0.
REQ-007 exe_valid_i  input  1  EXE holds a valid, non-bubble instruction.
REQ-008 exe_pc_i  input  32  PC of the EXE instruction.
REQ-009 mret_i, wfi_i  input  1 each  EXE instruction is MRET / WFI.
REQ-010 ext_irq_i, timer_irq_i  input  1 each  level-sensitive interrupt lines.
REQ-011 retire_i  input  1  one instruction retires this cycle.
REQ-012 csr_rdata_o  output  32  old CSR value for rd.
REQ-013 csr_int_o  output  1  interrupt taken; hazard unit flushes on it.
REQ-014 csr_mret_o  output  1  MRET taken; hazard unit flushes on it.
REQ-015 csr_pc_o  output  32  redirect target, valid when csr_int_o or csr_mret_o.
REQ-016 csr_stall_o  output  1  hold pipeline (WFI wait).

Function
REQ-017 Registers: mstatus 0x300 (MIE bit3, MPIE bit7, MPP[12:11] reads 11, other bits 0); mie 0x304 (MTIE bit7, MEIE bit11 writable, rest 0); mtvec 0x305 ([31:2] writable, [1:0] read 0, direct mode); mepc 0x341 ([31:2] writable, [1:0] 0); mip 0x344 read-only (MTIP bit7 = timer_irq_i, MEIP bit11 = ext_irq_i).
REQ-018 Counters: mcycle/mcycleh 0xB00/0xB80 and minstret/minstreth 0xB02/0xB82, 64-bit each, read-only; writes ignored.
REQ-019 mcycle increments every cycle rst_n=1; minstret increments when retire_i=1; both wrap 2^64-1 -> 0.
REQ-020 Unimplemented address reads 0; writes ignored; no exception raised.
REQ-021 csr_rdata_o combinational, pre-write value of csr_addr_i; 0 when csr_op_i is none.
REQ-022 Write rules: RW/RWI new = wdata; RS/RSI new = old | wdata; RC/RCI new = old & ~wdata; RS/RC/RSI/RCI with csr_src_zero_i=1 perform no write; writes commit on next edge, only when exe_valid_i=1.
REQ-023 pending = mstatus.MIE & ((mie.MEIE & ext_irq_i) | (mie.MTIE & timer_irq_i)); wake = (mie.MEIE & ext_irq_i) | (mie.MTIE & timer_irq_i).
REQ-024 FSM states RUN, WFI; reset state RUN.
REQ-025 RUN, exe_valid_i & pending: csr_int_o=1, csr_pc_o=mtvec; next edge mepc<=exe_pc_i, MPIE<=MIE, MIE<=0; CSR write and MRET of that instruction suppressed.
REQ-026 RUN, exe_valid_i & mret_i & ~pending: csr_mret_o=1, csr_pc_o=mepc; next edge MIE<=MPIE, MPIE<=1.
REQ-027 RUN, exe_valid_i & wfi_i & ~pending: if wake=0 go WFI next edge; if wake=1 act as NOP.
REQ-028 WFI: csr_stall_o=1 while wake=0; when wake=1: csr_stall_o=0, go RUN; if MIE=1 also csr_int_o=1, csr_pc_o=mtvec, mepc<=exe_pc_i+4, MPIE<=MIE, MIE<=0.
REQ-029 csr_int_o and csr_mret_o never both 1; each pulses exactly one cycle per event.
REQ-030 A CSR write to mstatus/mie affects pending from the following cycle only.
REQ-031 Outputs csr_int_o, csr_mret_o, csr_stall_o, csr_pc_o are 0 whenever neither event nor stall is active.

Reset
REQ-032 While rst_n=0 at an edge: state<=RUN, mstatus MIE=0 MPIE=0, mie=0, mtvec=0, mepc=0, mcycle=0, minstret=0.
REQ-033 During reset cycles all outputs 0 except csr_rdata_o, which follows REQ-021; reset in WFI returns to RUN with csr_stall_o=0 next cycle.

Verification
REQ-034 CSRRW 0x305 wdata 0x0000_1003 -> rdata 0; subsequent read of mtvec = 0x0000_1000.
REQ-035 CSRRS 0x300 wdata 0x8 (MIE=1), mie=0x800, ext_irq_i=1, exe_pc_i=0x0000_0040 -> csr_int_o=1, csr_pc_o=mtvec; next cycle mepc=0x40, mstatus=0x1880.
REQ-036 MRET after REQ-035 -> csr_mret_o=1, csr_pc_o=0x40; next cycle mstatus=0x1888.
REQ-037 WFI at pc 0x80, MIE=1, MTIE=1, timer raised 5 cycles later -> csr_stall_o=1 for 5 cycles, then csr_int_o=1 one cycle, mepc=0x84.
REQ-038 CSRRS 0xB00 with csr_src_zero_i=1 after 10 post-reset cycles -> rdata=10; CSRRC 0x300 with csr_src_zero_i=1 leaves mstatus unchanged.
REQ-039 rst_n=0 during WFI stall -> next cycle csr_stall_o=0, mstatus=0x1800, mcycle=0.
